// File: rtl/data_ram_arbiter.sv
// Two-host arbiter in front of the single-port data RAM; out-of-window accesses get a local error.
// Latency: gnt in the request cycle, rvalid (RAM or error) exactly one cycle later.
// Backpressure: the losing host sees gnt=0 and holds its request; a grant is possible every cycle.
module data_ram_arbiter #(
    parameter int unsigned Depth     = 128,
    parameter logic [31:0] BaseAddr  = 32'h0010_0000,
    parameter bit          FixedPrio = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        h0_req_i,
    output logic        h0_gnt_o,
    input  logic        h0_we_i,
    input  logic [3:0]  h0_be_i,
    input  logic [31:0] h0_addr_i,
    input  logic [31:0] h0_wdata_i,
    output logic        h0_rvalid_o,
    output logic [31:0] h0_rdata_o,
    output logic        h0_err_o,

    input  logic        h1_req_i,
    output logic        h1_gnt_o,
    input  logic        h1_we_i,
    input  logic [3:0]  h1_be_i,
    input  logic [31:0] h1_addr_i,
    input  logic [31:0] h1_wdata_i,
    output logic        h1_rvalid_o,
    output logic [31:0] h1_rdata_o,
    output logic        h1_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    localparam int unsigned Aw = $clog2(Depth);

    logic        both_req;
    logic        any_req;
    logic        win_h1;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_in_range;
    logic        fwd;
    logic        err_grant;

    logic        prio_q;
    logic        ram_pend_q;
    logic        rsp_host_q;
    logic        err_pend_q;
    logic        err_host_q;

    logic        ram_rsp;
    logic        ram_rsp_h0;
    logic        ram_rsp_h1;

    always_comb begin
        both_req = h0_req_i & h1_req_i;
        any_req  = h0_req_i | h1_req_i;
        // prio_q names the host that wins the next contended cycle
        if (both_req) begin
            win_h1 = FixedPrio ? 1'b0 : prio_q;
        end else begin
            win_h1 = h1_req_i;
        end

        sel_we    = win_h1 ? h1_we_i    : h0_we_i;
        sel_be    = win_h1 ? h1_be_i    : h0_be_i;
        sel_addr  = win_h1 ? h1_addr_i  : h0_addr_i;
        sel_wdata = win_h1 ? h1_wdata_i : h0_wdata_i;

        sel_in_range = (sel_addr[31:Aw+2] == BaseAddr[31:Aw+2]);
        fwd          = any_req & sel_in_range;
        err_grant    = any_req & ~sel_in_range;
    end

    assign h0_gnt_o = h0_req_i & ~win_h1;
    assign h1_gnt_o = h1_req_i &  win_h1;

    assign ram_req_o   = fwd;
    assign ram_we_o    = fwd & sel_we;
    assign ram_be_o    = fwd ? sel_be    : 4'b0000;
    assign ram_addr_o  = fwd ? sel_addr  : 32'h0;
    assign ram_wdata_o = fwd ? sel_wdata : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= 1'b0;
            ram_pend_q <= 1'b0;
            rsp_host_q <= 1'b0;
            err_pend_q <= 1'b0;
            err_host_q <= 1'b0;
        end else begin
            ram_pend_q <= fwd;
            err_pend_q <= err_grant;
            if (fwd) begin
                rsp_host_q <= win_h1;
            end
            if (err_grant) begin
                err_host_q <= win_h1;
            end
            if (both_req) begin
                prio_q <= ~win_h1;
            end
        end
    end

    // A RAM rvalid with nothing outstanding (e.g. after reset) is dropped here
    assign ram_rsp    = ram_pend_q & ram_rvalid_i;
    assign ram_rsp_h0 = ram_rsp & ~rsp_host_q;
    assign ram_rsp_h1 = ram_rsp &  rsp_host_q;

    assign h0_rvalid_o = ram_rsp_h0 | (err_pend_q & ~err_host_q);
    assign h0_rdata_o  = ram_rsp_h0 ? ram_rdata_i : 32'h0;
    assign h0_err_o    = err_pend_q & ~err_host_q;

    assign h1_rvalid_o = ram_rsp_h1 | (err_pend_q & err_host_q);
    assign h1_rdata_o  = ram_rsp_h1 ? ram_rdata_i : 32'h0;
    assign h1_err_o    = err_pend_q & err_host_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: round-robin and fixed-priority instances share host stimulus,
// each with its own 1-cycle RAM model; responses are checked by a queue-based monitor.
module tb_data_ram_arbiter;

    localparam int Depth = 128;

    typedef struct {
        int          inst;
        int          host;
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic stray  = 1'b0;

    logic        h0_req, h0_we, h1_req, h1_we;
    logic [3:0]  h0_be, h1_be;
    logic [31:0] h0_addr, h0_wdata, h1_addr, h1_wdata;

    logic [1:0]  gnt0, gnt1, rv0, rv1, er0, er1;
    logic [1:0]  ram_req, ram_we, model_rv, ram_rv;
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [3:0]  ram_be [2];
    logic [31:0] ram_addr [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic [31:0] mem [2][Depth];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    assign ram_rv = model_rv | {stray, stray};

    data_ram_arbiter #(.Depth(Depth), .BaseAddr(32'h0010_0000), .FixedPrio(1'b0)) u_rr (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h0_req_i(h0_req), .h0_gnt_o(gnt0[0]), .h0_we_i(h0_we), .h0_be_i(h0_be),
        .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata), .h0_rvalid_o(rv0[0]), .h0_rdata_o(rd0[0]),
        .h0_err_o(er0[0]),
        .h1_req_i(h1_req), .h1_gnt_o(gnt1[0]), .h1_we_i(h1_we), .h1_be_i(h1_be),
        .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata), .h1_rvalid_o(rv1[0]), .h1_rdata_o(rd1[0]),
        .h1_err_o(er1[0]),
        .ram_req_o(ram_req[0]), .ram_we_o(ram_we[0]), .ram_be_o(ram_be[0]),
        .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]),
        .ram_rvalid_i(ram_rv[0]), .ram_rdata_i(ram_rdata[0])
    );

    data_ram_arbiter #(.Depth(Depth), .BaseAddr(32'h0010_0000), .FixedPrio(1'b1)) u_fp (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h0_req_i(h0_req), .h0_gnt_o(gnt0[1]), .h0_we_i(h0_we), .h0_be_i(h0_be),
        .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata), .h0_rvalid_o(rv0[1]), .h0_rdata_o(rd0[1]),
        .h0_err_o(er0[1]),
        .h1_req_i(h1_req), .h1_gnt_o(gnt1[1]), .h1_we_i(h1_we), .h1_be_i(h1_be),
        .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata), .h1_rvalid_o(rv1[1]), .h1_rdata_o(rd1[1]),
        .h1_err_o(er1[1]),
        .ram_req_o(ram_req[1]), .ram_we_o(ram_we[1]), .ram_be_o(ram_be[1]),
        .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]),
        .ram_rvalid_i(ram_rv[1]), .ram_rdata_i(ram_rdata[1])
    );

    // RAM models: word w starts as A5A5_00ww; writes respond with rdata 0
    always @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (cyc == 0) begin
                for (int w = 0; w < Depth; w++) mem[i][w] <= 32'hA5A5_0000 | w;
                model_rv[i]  <= 1'b0;
                ram_rdata[i] <= 32'h0;
            end else begin
                model_rv[i]  <= ram_req[i];
                ram_rdata[i] <= ram_we[i] ? 32'h0 : mem[i][ram_addr[i][8:2]];
                if (ram_req[i] && ram_we[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_be[i][b]) mem[i][ram_addr[i][8:2]][b*8 +: 8] <= ram_wdata[i][b*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drv(input int h, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
        if (h == 0) begin
            h0_req = req; h0_we = we; h0_be = be; h0_addr = addr; h0_wdata = wd;
        end else begin
            h1_req = req; h1_we = we; h1_be = be; h1_addr = addr; h1_wdata = wd;
        end
    endtask

    task automatic idle_all();
        drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic push(input int inst, input int host, input logic [31:0] rd, input logic er);
        exp_t e;
        e.inst = inst; e.host = host; e.due = cyc + 1; e.rdata = rd; e.err = er;
        sb.push_back(e);
    endtask

    task automatic push2(input int host, input logic [31:0] rd, input logic er);
        push(0, host, rd, er);
        push(1, host, rd, er);
    endtask

    // Check grants/ram_req mid-cycle, then advance to just after the next rising edge
    task automatic step(input string nm, input logic g0r, input logic g1r,
                        input logic g0f, input logic g1f, input logic rq);
        @(negedge clk_i);
        chk({nm, "_gnt0_rr"}, {31'h0, gnt0[0]}, {31'h0, g0r});
        chk({nm, "_gnt1_rr"}, {31'h0, gnt1[0]}, {31'h0, g1r});
        chk({nm, "_gnt0_fp"}, {31'h0, gnt0[1]}, {31'h0, g0f});
        chk({nm, "_gnt1_fp"}, {31'h0, gnt1[1]}, {31'h0, g1f});
        chk({nm, "_ramreq_rr"}, {31'h0, ram_req[0]}, {31'h0, rq});
        chk({nm, "_ramreq_fp"}, {31'h0, ram_req[1]}, {31'h0, rq});
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every host rvalid must match the oldest pending expectation for that host
    always @(negedge clk_i) begin
        logic        v;
        logic        e;
        logic [31:0] rd;
        int          hit;
        for (int i = 0; i < 2; i++) begin
            for (int h = 0; h < 2; h++) begin
                v  = (h == 0) ? rv0[i] : rv1[i];
                e  = (h == 0) ? er0[i] : er1[i];
                rd = (h == 0) ? rd0[i] : rd1[i];
                if (v) begin
                    hit = -1;
                    for (int j = 0; j < sb.size(); j++)
                        if (hit < 0 && sb[j].inst == i && sb[j].host == h) hit = j;
                    checks++;
                    if (hit < 0) begin
                        failures++;
                        $display("FAIL unexpected_rvalid inst%0d h%0d: got rvalid=1 expected 0 (cyc %0d)", i, h, cyc);
                    end else begin
                        if (sb[hit].due != cyc || rd !== sb[hit].rdata || e !== sb[hit].err) begin
                            failures++;
                            $display("FAIL rsp inst%0d h%0d: got cyc=%0d rdata=%h err=%b expected cyc=%0d rdata=%h err=%b",
                                     i, h, cyc, rd, e, sb[hit].due, sb[hit].rdata, sb[hit].err);
                        end
                        sb.delete(hit);
                    end
                end
            end
        end
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_rvalid inst%0d h%0d: got none expected at cyc %0d", sb[j].inst, sb[j].host, sb[j].due);
                sb.delete(j);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rst_gnt0", {30'h0, gnt0}, 32'h0);
        chk("rst_ramreq", {30'h0, ram_req}, 32'h0);
        chk("rst_rvalid", {28'h0, rv0, rv1}, 32'h0);
        chk("rst_err", {28'h0, er0, er1}, 32'h0);
        chk("rst_rdata", rd0[0] | rd1[0] | rd0[1] | rd1[1], 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Partial write then read back
        drv(0, 1'b1, 1'b1, 4'b0011, 32'h0010_0008, 32'hDEAD_BEEF);
        push2(0, 32'h0, 1'b0);
        step("t1_wr", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drv(0, 1'b1, 1'b0, 4'hF, 32'h0010_0008, 32'h0);
        push2(0, 32'hA5A5_BEEF, 1'b0);
        step("t1_rd", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_all();
        step("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Contention: round-robin alternates, fixed priority keeps host 0
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b1, 1'b0, 4'hF, 32'h0010_0010, 32'h0);
            drv(1, 1'b1, 1'b0, 4'hF, 32'h0010_0020, 32'h0);
            if (i % 2 == 0) push(0, 0, 32'hA5A5_0004, 1'b0);
            else            push(0, 1, 32'hA5A5_0008, 1'b0);
            push(1, 0, 32'hA5A5_0004, 1'b0);
            step("t2_both", i % 2 == 0, i % 2 == 1, 1'b1, 1'b0, 1'b1);
        end
        drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        push2(1, 32'hA5A5_0008, 1'b0);
        step("t3_h1only", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drv(0, 1'b1, 1'b0, 4'hF, 32'h0010_0010, 32'h0);
        drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        push2(0, 32'hA5A5_0004, 1'b0);
        step("t3_h0only", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drv(1, 1'b1, 1'b0, 4'hF, 32'h0010_0020, 32'h0);
        push2(0, 32'hA5A5_0004, 1'b0);
        step("t3_both_again", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_all();
        step("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Out-of-window access answered locally
        drv(1, 1'b1, 1'b0, 4'hF, 32'h0020_0000, 32'h0);
        push2(1, 32'h0, 1'b1);
        step("t4_oor", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_all();
        step("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // RAM response then error response on consecutive cycles
        drv(0, 1'b1, 1'b0, 4'hF, 32'h0010_000C, 32'h0);
        push2(0, 32'hA5A5_0003, 1'b0);
        step("t5_h0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(1, 1'b1, 1'b0, 4'hF, 32'h0020_0004, 32'h0);
        push2(1, 32'h0, 1'b1);
        step("t5_h1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_all();
        step("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with a read outstanding: the response is dropped and priority returns to host 0
        drv(0, 1'b1, 1'b0, 4'hF, 32'h0010_0018, 32'h0);
        step("t6_rd", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        rst_ni = 1'b0;
        idle_all();
        @(negedge clk_i);
        chk("t6_rst_rvalid", {28'h0, rv0, rv1}, 32'h0);
        chk("t6_rst_ramreq", {30'h0, ram_req}, 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        stray  = 1'b1;
        @(posedge clk_i);
        #1;
        stray = 1'b0;
        drv(0, 1'b1, 1'b0, 4'hF, 32'h0010_0010, 32'h0);
        drv(1, 1'b1, 1'b0, 4'hF, 32'h0010_0020, 32'h0);
        push(0, 0, 32'hA5A5_0004, 1'b0);
        push(1, 0, 32'hA5A5_0004, 1'b0);
        step("t6_prio_first", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        push(0, 1, 32'hA5A5_0008, 1'b0);
        push(1, 0, 32'hA5A5_0004, 1'b0);
        step("t6_prio_second", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_all();
        repeat (3) @(posedge clk_i);
        #1;
        chk("sb_empty", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
